mod_addition_pipe: RTL and testbench

- Elastic, 2-stage pipelined modular adder: result = (a + b) mod `mod`, with a valid/ready handshake on both sides.
- Complements the NTT modular subtractor. The two together form the add/sub halves of the butterfly datapath.
- Sits between the twiddle-multiplier output and the coefficient write-back path.
- Carries a sideband tag (coefficient index) alongside each beat.

---
 rtl/ntt_pkg.sv | 17 +
 rtl/elastic_pipe_reg.sv | 40 ++++
 rtl/mod_addition_pipe.sv | 99 +++++++++
 tb/tb_mod_addition_pipe.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT butterfly datapath (modular add/sub halves).
// Provides default coefficient/modulus width and tag width, plus the basic
// coefficient, tag and beat types used between datapath blocks.
package ntt_pkg;

  localparam int K_DEF     = 32;
  localparam int TAG_W_DEF = 16;

  typedef logic [K_DEF-1:0]     coeff_t;
  typedef logic [TAG_W_DEF-1:0] tag_t;

  typedef struct packed {
    coeff_t val;
    tag_t   tag;
  } beat_s;

endpackage

// File: rtl/elastic_pipe_reg.sv
// One elastic pipeline stage: a valid bit plus a W-bit data register with
// hold-on-stall behaviour.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid / in_ready  upstream handshake; in_ready = stage may advance
//   in_data              data captured on in_valid && in_ready
//   out_valid/out_ready  downstream handshake
//   out_data             registered data, stable while stalled
module elastic_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         vld;
  logic [W-1:0] data;

  // The stage can take a new beat when empty or when its beat leaves now.
  assign in_ready  = !vld || out_ready;
  assign out_valid = vld;
  assign out_data  = data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld  <= 1'b0;
      data <= '0;
    end else if (in_ready) begin
      vld <= in_valid;
      if (in_valid) data <= in_data;
    end
  end

endmodule

// File: rtl/mod_addition_pipe.sv
// Elastic 2-stage modular adder: result = (a + b) mod mod, with valid/ready
// handshakes on both sides and a sideband tag carried with each beat.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid, in_ready        input handshake for {a, b, tag}
//   a, b                      addends, each expected < mod
//   tag                       sideband passed through unchanged
//   mod                       modulus, only changed while the pipe is empty
//   out_valid, out_ready      output handshake
//   result, out_tag           (a + b) mod mod and the matching tag
//   busy                      any stage holds a valid beat
module mod_addition_pipe
  import ntt_pkg::*;
#(
  parameter int K     = K_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [K-1:0]     a,
  input  logic [K-1:0]     b,
  input  logic [TAG_W-1:0] tag,
  input  logic [K-1:0]     mod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [K-1:0]     result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int S1_W = (K + 1) + 1 + K + TAG_W;
  localparam int S2_W = K + TAG_W;

  // Single conditional correction: keep the raw sum when sum - mod borrows.
  // A carry into bit K means sum >= 2^K > mod, so no borrow is possible.
  function automatic logic [K-1:0] mod_select(input logic [K:0]   sum,
                                               input logic         neg,
                                               input logic [K-1:0] diff_lo);
    return (neg && !sum[K]) ? sum[K-1:0] : diff_lo;
  endfunction

  logic [K:0]      sum_p0;
  logic            neg_p0;
  logic [K-1:0]    diff_p0;
  logic [S1_W-1:0] s1_in;

  logic            vld_p1;
  logic [S1_W-1:0] s1_out;
  logic [K:0]      sum_p1;
  logic            neg_p1;
  logic [K-1:0]    diff_p1;
  logic [TAG_W-1:0] tag_p1;
  logic            s2_ready;

  logic            vld_p2;
  logic [S2_W-1:0] s2_in;
  logic [S2_W-1:0] s2_out;

  // ---- Stage 0 -> 1: full-width sum and trial subtraction ----
  // neg_p0 is the sign of the (K+2)-bit signed value sum - mod.
  assign sum_p0  = {1'b0, a} + {1'b0, b};
  assign neg_p0  = sum_p0 < {1'b0, mod};
  assign diff_p0 = sum_p0[K-1:0] - mod;
  assign s1_in   = {sum_p0, neg_p0, diff_p0, tag};

  elastic_pipe_reg #(.W(S1_W)) u_stage1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (s1_in),
    .out_valid (vld_p1),
    .out_ready (s2_ready),
    .out_data  (s1_out)
  );

  // ---- Stage 1 -> 2: select corrected value ----
  assign {sum_p1, neg_p1, diff_p1, tag_p1} = s1_out;
  assign s2_in = {mod_select(sum_p1, neg_p1, diff_p1), tag_p1};

  elastic_pipe_reg #(.W(S2_W)) u_stage2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (vld_p1),
    .in_ready  (s2_ready),
    .in_data   (s2_in),
    .out_valid (vld_p2),
    .out_ready (out_ready),
    .out_data  (s2_out)
  );

  // ---- Stage 2 outputs ----
  assign {result, out_tag} = s2_out;
  assign out_valid = vld_p2;
  assign busy      = vld_p1 || vld_p2;

endmodule

// File: tb/tb_mod_addition_pipe.sv
// Self-checking bench for mod_addition_pipe (K=32, TAG_W=16).
module tb_mod_addition_pipe;

  localparam int K     = 32;
  localparam int TAG_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [K-1:0]     a;
  logic [K-1:0]     b;
  logic [TAG_W-1:0] tag;
  logic [K-1:0]     mod;
  logic             out_valid;
  logic             out_ready;
  logic [K-1:0]     result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [K-1:0]     val;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t exp_q[$];

  mod_addition_pipe #(.K(K), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .tag       (tag),
    .mod       (mod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .out_tag   (out_tag),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference: plain modular arithmetic on 64-bit integers.
  function automatic logic [K-1:0] ref_add(input logic [K-1:0] x, input logic [K-1:0] y,
                                           input logic [K-1:0] m);
    logic [63:0] s;
    s = 64'(x) + 64'(y);
    return K'(s % 64'(m));
  endfunction

  // Drive one cycle of inputs and report what the DUT showed before the edge.
  task automatic step(input logic iv, input logic [K-1:0] ia, input logic [K-1:0] ib,
                      input logic [TAG_W-1:0] itag, input logic ior,
                      output logic acc, output logic drn, output logic [K-1:0] r,
                      output logic [TAG_W-1:0] t, output logic ir, output logic ov,
                      output logic bz);
    in_valid  = iv;
    a         = ia;
    b         = ib;
    tag       = itag;
    out_ready = ior;
    #1;
    acc = in_valid && in_ready;
    drn = out_valid && out_ready;
    r   = result;
    t   = out_tag;
    ir  = in_ready;
    ov  = out_valid;
    bz  = busy;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; tag = '0; mod = 32'd17;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (result !== '0) $display("FAIL reset_result: got %0h want 0", result); else n_pass++;
    n_checks++; if (out_tag !== '0) $display("FAIL reset_out_tag: got %0h want 0", out_tag); else n_pass++;
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL idle_out_valid: got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_single();
    logic acc, drn, ir, ov, bz;
    logic [K-1:0] r;
    logic [TAG_W-1:0] t;
    mod = 32'd17;
    step(1'b1, 32'd10, 32'd9, 16'd5, 1'b1, acc, drn, r, t, ir, ov, bz);
    n_checks++; if (acc !== 1'b1) $display("FAIL single_accept: got %b want 1", acc); else n_pass++;
    step(1'b0, '0, '0, '0, 1'b1, acc, drn, r, t, ir, ov, bz);
    n_checks++; if (ov !== 1'b0) $display("FAIL single_early_valid: got %b want 0", ov); else n_pass++;
    step(1'b0, '0, '0, '0, 1'b1, acc, drn, r, t, ir, ov, bz);
    n_checks++; if (ov !== 1'b1) $display("FAIL single_latency: got %b want 1", ov); else n_pass++;
    n_checks++; if (r !== 32'd2) $display("FAIL single_result: got %0d want 2", r); else n_pass++;
    n_checks++; if (t !== 16'd5) $display("FAIL single_tag: got %0d want 5", t); else n_pass++;
    step(1'b0, '0, '0, '0, 1'b1, acc, drn, r, t, ir, ov, bz);
    n_checks++; if (ov !== 1'b0) $display("FAIL single_once: got %b want 0", ov); else n_pass++;
  endtask

  task automatic test_boundaries();
    logic acc, drn, ir, ov, bz, got;
    logic [K-1:0] r;
    logic [TAG_W-1:0] t;
    logic [K-1:0] ta [5];
    logic [K-1:0] tb [5];
    logic [K-1:0] tm [5];
    logic [K-1:0] te [5];
    ta = '{32'd16, 32'd16, 32'd0, 32'd8, 32'hFFFFFFFA};
    tb = '{32'd1,  32'd16, 32'd0, 32'd8, 32'hFFFFFFFA};
    tm = '{32'd17, 32'd17, 32'd17, 32'd17, 32'hFFFFFFFB};
    te = '{32'd0,  32'd15, 32'd0, 32'd16, 32'hFFFFFFF9};
    for (int i = 0; i < 5; i++) begin
      mod = tm[i];
      step(1'b1, ta[i], tb[i], TAG_W'(100 + i), 1'b1, acc, drn, r, t, ir, ov, bz);
      got = 1'b0;
      for (int c = 0; c < 6 && !got; c++) begin
        step(1'b0, '0, '0, '0, 1'b1, acc, drn, r, t, ir, ov, bz);
        if (drn) begin
          got = 1'b1;
          n_checks++; if (r !== te[i]) $display("FAIL boundary_%0d_result: got %0h want %0h", i, r, te[i]); else n_pass++;
          n_checks++; if (t !== TAG_W'(100 + i)) $display("FAIL boundary_%0d_tag: got %0d want %0d", i, t, 100 + i); else n_pass++;
        end
      end
      n_checks++; if (got !== 1'b1) $display("FAIL boundary_%0d_timeout: got no output want one", i); else n_pass++;
    end
    mod = 32'd17;
  endtask

  task automatic test_stream();
    logic acc, drn, ir, ov, bz;
    logic [K-1:0] r, va, vb;
    logic [TAG_W-1:0] t;
    exp_t e;
    int sent, drained, last_drain;
    sent = 0; drained = 0; last_drain = 0;
    mod = 32'd17;
    for (int cyc = 1; cyc <= 110; cyc++) begin
      va = $urandom % mod;
      vb = $urandom % mod;
      step(sent < 100, va, vb, TAG_W'(sent), 1'b1, acc, drn, r, t, ir, ov, bz);
      if (acc) begin
        exp_q.push_back('{val: ref_add(va, vb, mod), tag: TAG_W'(sent)});
        sent++;
      end
      if (drn) begin
        if (exp_q.size() == 0) begin
          n_checks++; $display("FAIL stream_extra: got output %0h want none", r);
        end else begin
          e = exp_q.pop_front();
          n_checks++; if (r !== e.val) $display("FAIL stream_result: got %0h want %0h", r, e.val); else n_pass++;
          n_checks++; if (t !== e.tag) $display("FAIL stream_tag: got %0d want %0d", t, e.tag); else n_pass++;
        end
        drained++;
        last_drain = cyc;
      end
    end
    n_checks++; if (drained !== 100) $display("FAIL stream_count: got %0d want 100", drained); else n_pass++;
    n_checks++; if (last_drain !== 102) $display("FAIL stream_rate: got last at %0d want 102", last_drain); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic acc, drn, ir, ov, bz, have_ref;
    logic [K-1:0] r, hold_r;
    logic [TAG_W-1:0] t, hold_t;
    logic [K-1:0] pa [4];
    exp_t e;
    int idx, drained;
    pa = '{32'd3, 32'd11, 32'd14, 32'd7};
    idx = 0; drained = 0; have_ref = 1'b0; hold_r = '0; hold_t = '0;
    mod = 32'd17;
    for (int c = 0; c < 5; c++) begin
      step(1'b1, pa[idx], pa[3 - idx], TAG_W'(200 + idx), 1'b0, acc, drn, r, t, ir, ov, bz);
      if (c >= 2) begin
        n_checks++; if (ir !== 1'b0) $display("FAIL bp_in_ready_c%0d: got %b want 0", c, ir); else n_pass++;
      end
      if (ov && have_ref) begin
        n_checks++; if (r !== hold_r || t !== hold_t)
          $display("FAIL bp_hold: got %0h/%0d want %0h/%0d", r, t, hold_r, hold_t); else n_pass++;
      end
      if (ov && !have_ref) begin
        have_ref = 1'b1; hold_r = r; hold_t = t;
      end
      if (acc) begin
        exp_q.push_back('{val: ref_add(pa[idx], pa[3 - idx], mod), tag: TAG_W'(200 + idx)});
        idx++;
      end
    end
    n_checks++; if (idx !== 2) $display("FAIL bp_accepted: got %0d want 2", idx); else n_pass++;
    for (int c = 0; c < 6; c++) begin
      step(1'b0, '0, '0, '0, 1'b1, acc, drn, r, t, ir, ov, bz);
      if (drn) begin
        if (exp_q.size() == 0) begin
          n_checks++; $display("FAIL bp_duplicate: got output %0h want none", r);
        end else begin
          e = exp_q.pop_front();
          n_checks++; if (r !== e.val || t !== e.tag)
            $display("FAIL bp_drain: got %0h/%0d want %0h/%0d", r, t, e.val, e.tag); else n_pass++;
          drained++;
        end
      end
    end
    n_checks++; if (drained !== 2) $display("FAIL bp_drained: got %0d want 2", drained); else n_pass++;
    exp_q.delete();
  endtask

  task automatic test_reset_midstream();
    logic acc, drn, ir, ov, bz;
    logic [K-1:0] r;
    logic [TAG_W-1:0] t;
    mod = 32'd17;
    step(1'b1, 32'd3, 32'd4, 16'd1, 1'b0, acc, drn, r, t, ir, ov, bz);
    step(1'b1, 32'd5, 32'd6, 16'd2, 1'b0, acc, drn, r, t, ir, ov, bz);
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL rst_mid_loaded: got %b want 1", out_valid); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_mid_async_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_mid_async_busy: got %b want 0", busy); else n_pass++;
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_mid_in_ready: got %b want 1", in_ready); else n_pass++;
    @(posedge clk);
    #1;
    for (int c = 0; c < 5; c++) begin
      step(1'b0, '0, '0, '0, 1'b1, acc, drn, r, t, ir, ov, bz);
      n_checks++; if (ov !== 1'b0) $display("FAIL rst_mid_ghost_c%0d: got %b want 0", c, ov); else n_pass++;
    end
  endtask

  task automatic test_random();
    logic acc, drn, ir, ov, bz, iv, ordy, pend;
    logic prev_stall;
    logic [K-1:0] r, pa, pb, prev_r, exp_ir_r;
    logic [TAG_W-1:0] t, prev_t;
    logic exp_ir;
    exp_t e;
    int sent, drained, cyc;
    sent = 0; drained = 0; cyc = 0; pend = 1'b0; prev_stall = 1'b0;
    pa = '0; pb = '0; prev_r = '0; prev_t = '0; exp_ir_r = '0;
    mod = $urandom_range(32'hFFFF_FFFF, 2);
    while ((sent < 1000 || drained < 1000) && cyc < 20000) begin
      if (!pend && sent < 1000) begin
        pa = $urandom % mod;
        pb = $urandom % mod;
        pend = 1'b1;
      end
      iv   = pend && ($urandom_range(1, 0) == 1);
      ordy = ($urandom_range(1, 0) == 1);
      exp_ir = !(exp_q.size() == 2 && !ordy);
      step(iv, pa, pb, TAG_W'(sent), ordy, acc, drn, r, t, ir, ov, bz);
      n_checks++; if (ir !== exp_ir) $display("FAIL rand_in_ready: got %b want %b occ %0d", ir, exp_ir, exp_q.size()); else n_pass++;
      n_checks++; if (bz !== (exp_q.size() != 0)) $display("FAIL rand_busy: got %b want %b", bz, exp_q.size() != 0); else n_pass++;
      if (prev_stall) begin
        n_checks++; if (ov !== 1'b1 || r !== prev_r || t !== prev_t)
          $display("FAIL rand_stable: got %b/%0h/%0d want 1/%0h/%0d", ov, r, t, prev_r, prev_t); else n_pass++;
      end
      prev_stall = ov && !ordy;
      prev_r = r;
      prev_t = t;
      if (drn) begin
        if (exp_q.size() == 0) begin
          n_checks++; $display("FAIL rand_extra: got output %0h want none", r);
        end else begin
          e = exp_q.pop_front();
          n_checks++; if (r !== e.val || t !== e.tag)
            $display("FAIL rand_data: got %0h/%0d want %0h/%0d", r, t, e.val, e.tag); else n_pass++;
        end
        drained++;
      end
      if (acc) begin
        exp_q.push_back('{val: ref_add(pa, pb, mod), tag: TAG_W'(sent)});
        sent++;
        pend = 1'b0;
      end
      cyc++;
    end
    n_checks++; if (drained !== 1000 || sent !== 1000)
      $display("FAIL rand_timeout: got sent %0d drained %0d want 1000/1000", sent, drained); else n_pass++;
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_boundaries();
    test_stream();
    test_backpressure();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
